// File: rtl/time_display_scan_pkg.sv
// Shared segment codes, digit indices and converter state encoding for the
// time display scanner and its double-dabble converters.
package time_display_scan_pkg;

    // Segment order {g,f,e,d,c,b,a}, logical (active-high) polarity
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [1:0] DIG_SEC_U = 2'd0;
    localparam logic [1:0] DIG_SEC_T = 2'd1;
    localparam logic [1:0] DIG_MIN_U = 2'd2;
    localparam logic [1:0] DIG_MIN_T = 2'd3;

    localparam int unsigned CONV_SHIFTS = 6;

    typedef enum logic [1:0] {
        CONV_IDLE  = 2'd0,
        CONV_LOAD  = 2'd1,
        CONV_SHIFT = 2'd2,
        CONV_DONE  = 2'd3
    } conv_state_e;

    function automatic logic [6:0] seg_encode(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/time_display_scan_bin2bcd_seq.sv
// Sequential double-dabble: 6-bit binary to two BCD nibbles {tens, units}.
// start_i in IDLE -> LOAD -> 6x SHIFT -> DONE; result held in bcd_o afterwards.
module bin2bcd_seq
    import time_display_scan_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic [5:0] bin_i,
    output logic       done_o,
    output logic [7:0] bcd_o
);

    localparam logic [2:0] LAST_SHIFT = 3'(CONV_SHIFTS - 1);

    conv_state_e state_q, state_d;
    logic [2:0]  shift_cnt_q, shift_cnt_d;
    logic [5:0]  bin_q, bin_d;
    logic [7:0]  bcd_q, bcd_d;
    logic [7:0]  bcd_adj;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= CONV_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            CONV_IDLE:  if (start_i) state_d = CONV_LOAD;
            CONV_LOAD:  state_d = CONV_SHIFT;
            CONV_SHIFT: if (shift_cnt_q == LAST_SHIFT) state_d = CONV_DONE;
            CONV_DONE:  state_d = CONV_IDLE;
            default:    state_d = CONV_IDLE;
        endcase
    end

    always_comb begin
        done_o = (state_q == CONV_DONE);
        bcd_o  = bcd_q;
    end

    // Add-3 correction applied to every nibble before each shift
    always_comb begin
        bcd_adj[3:0] = (bcd_q[3:0] >= 4'd5) ? bcd_q[3:0] + 4'd3 : bcd_q[3:0];
        bcd_adj[7:4] = (bcd_q[7:4] >= 4'd5) ? bcd_q[7:4] + 4'd3 : bcd_q[7:4];
    end

    always_comb begin
        bin_d       = bin_q;
        bcd_d       = bcd_q;
        shift_cnt_d = shift_cnt_q;
        case (state_q)
            CONV_LOAD: begin
                bin_d       = bin_i;
                bcd_d       = '0;
                shift_cnt_d = '0;
            end
            CONV_SHIFT: begin
                {bcd_d, bin_d} = 14'({bcd_adj, bin_q, 1'b0});
                shift_cnt_d    = shift_cnt_q + 3'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bin_q       <= '0;
            bcd_q       <= '0;
            shift_cnt_q <= '0;
        end else begin
            bin_q       <= bin_d;
            bcd_q       <= bcd_d;
            shift_cnt_q <= shift_cnt_d;
        end
    end

endmodule

// File: rtl/time_display_scan.sv
// Four-digit MM.SS multiplexed 7-segment scanner with per-frame input snapshots,
// dead time between digits and blinking. Option: DISP_LEADING_ZERO_BLANK_EN.
module time_display_scan
    import time_display_scan_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned BLINK_FRAMES = 50,
    parameter bit          ACTIVE_LOW   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] i_minutes,
    input  logic [5:0] i_seconds,
    input  logic       i_blink,
    output logic [6:0] o_seg,
    output logic       o_dp,
    output logic [3:0] o_digit_sel,
    output logic       o_frame_done
);

    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [FRM_W-1:0] FRAME_LAST = FRM_W'(BLINK_FRAMES - 1);

    logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]       digit_idx_q, digit_idx_d;
    logic [5:0]       min_snap_q, min_snap_d;
    logic [5:0]       sec_snap_q, sec_snap_d;
    logic             conv_ready_q, conv_ready_d;
    logic [15:0]      disp_bcd_q, disp_bcd_d;
    logic             disp_valid_q, disp_valid_d;
    logic [FRM_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             blink_phase_q, blink_phase_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic [3:0]       sel_q, sel_d;
    logic             frame_done_q, frame_done_d;

    logic       scan_tc, snap_evt, commit, lit;
    logic       min_done, sec_done;
    logic [7:0] min_bcd, sec_bcd;
    logic [3:0] digit_bcd;

    bin2bcd_seq u_min_conv (
        .clk_i   (clk),
        .rst_ni  (rst),
        .start_i (snap_evt),
        .bin_i   (min_snap_q),
        .done_o  (min_done),
        .bcd_o   (min_bcd)
    );

    bin2bcd_seq u_sec_conv (
        .clk_i   (clk),
        .rst_ni  (rst),
        .start_i (snap_evt),
        .bin_i   (sec_snap_q),
        .done_o  (sec_done),
        .bcd_o   (sec_bcd)
    );

    // Snapshot on entry to digit 3, commit on wrap back to digit 0
    always_comb begin
        scan_tc     = (scan_cnt_q == SCAN_LAST);
        snap_evt    = scan_tc && (digit_idx_q == DIG_MIN_U);
        commit      = scan_tc && (digit_idx_q == DIG_MIN_T);
        scan_cnt_d  = scan_tc ? '0 : scan_cnt_q + 1'b1;
        digit_idx_d = scan_tc ? digit_idx_q + 2'd1 : digit_idx_q;
        min_snap_d  = snap_evt ? i_minutes : min_snap_q;
        sec_snap_d  = snap_evt ? i_seconds : sec_snap_q;

        conv_ready_d = conv_ready_q;
        if (snap_evt) begin
            conv_ready_d = 1'b0;
        end else if (min_done && sec_done) begin
            conv_ready_d = 1'b1;
        end

        disp_bcd_d   = (commit && conv_ready_q) ? {min_bcd, sec_bcd} : disp_bcd_q;
        disp_valid_d = disp_valid_q | commit;
        frame_done_d = commit;
    end

    always_comb begin
        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;
        if (!i_blink) begin
            frame_cnt_d   = '0;
            blink_phase_d = 1'b0;
        end else if (commit) begin
            if (frame_cnt_q == FRAME_LAST) begin
                frame_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    // First cycle of each digit period is dead time: pattern changes, enables off
    always_comb begin
        digit_bcd = disp_bcd_q[{digit_idx_q, 2'b00} +: 4];
        lit       = disp_valid_q && (scan_cnt_q != '0) && !(i_blink && blink_phase_q);
        seg_d     = disp_valid_q ? seg_encode(digit_bcd) : SEG_BLANK;
        sel_d     = lit ? (4'b0001 << digit_idx_q) : 4'b0000;
        dp_d      = lit && (digit_idx_q == DIG_MIN_U);
`ifdef DISP_LEADING_ZERO_BLANK_EN
        if ((digit_idx_q == DIG_MIN_T) && (digit_bcd == 4'd0)) begin
            seg_d = SEG_BLANK;
            sel_d = 4'b0000;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt_q    <= '0;
            digit_idx_q   <= DIG_SEC_U;
            min_snap_q    <= '0;
            sec_snap_q    <= '0;
            conv_ready_q  <= 1'b0;
            disp_bcd_q    <= '0;
            disp_valid_q  <= 1'b0;
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            seg_q         <= SEG_BLANK;
            dp_q          <= 1'b0;
            sel_q         <= '0;
            frame_done_q  <= 1'b0;
        end else begin
            scan_cnt_q    <= scan_cnt_d;
            digit_idx_q   <= digit_idx_d;
            min_snap_q    <= min_snap_d;
            sec_snap_q    <= sec_snap_d;
            conv_ready_q  <= conv_ready_d;
            disp_bcd_q    <= disp_bcd_d;
            disp_valid_q  <= disp_valid_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            sel_q         <= sel_d;
            frame_done_q  <= frame_done_d;
        end
    end

    always_comb begin
        o_seg        = ACTIVE_LOW ? ~seg_q : seg_q;
        o_dp         = ACTIVE_LOW ? ~dp_q  : dp_q;
        o_digit_sel  = ACTIVE_LOW ? ~sel_q : sel_q;
        o_frame_done = frame_done_q;
    end

endmodule

// File: tb/tb_time_display_scan.sv
// Directed self-checking bench for time_display_scan (SCAN_DIV=10,
// BLINK_FRAMES=2, active-high pins); expected segments come from a local table.
module tb_time_display_scan;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] i_minutes = 6'd45;
    logic [5:0] i_seconds = 6'd7;
    logic       i_blink = 1'b0;
    logic [6:0] o_seg;
    logic       o_dp;
    logic [3:0] o_digit_sel;
    logic       o_frame_done;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    time_display_scan #(
        .SCAN_DIV     (10),
        .BLINK_FRAMES (2),
        .ACTIVE_LOW   (1'b0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_minutes    (i_minutes),
        .i_seconds    (i_seconds),
        .i_blink      (i_blink),
        .o_seg        (o_seg),
        .o_dp         (o_dp),
        .o_digit_sel  (o_digit_sel),
        .o_frame_done (o_frame_done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg7(input int unsigned n);
        case (n)
            0: return 7'b0111111;
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            5: return 7'b1101101;
            6: return 7'b1111101;
            7: return 7'b0000111;
            8: return 7'b1111111;
            9: return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    // {min tens, min units, sec tens, sec units}; digit d at [7*d +: 7]
    function automatic logic [27:0] frame_segs(input int unsigned mm, input int unsigned ss);
        return {seg7(mm / 10), seg7(mm % 10), seg7(ss / 10), seg7(ss % 10)};
    endfunction

    // Called at the negedge where o_frame_done is high; returns at the next one.
    task automatic check_frame(input string tag, input int unsigned mm, input int unsigned ss,
                               input logic [3:0] lit, input int unsigned upd_dig,
                               input logic [5:0] nm, input logic [5:0] ns, input logic nb);
        logic [27:0] segs;
        logic [3:0]  exp_sel;
        logic        exp_dp;
        int unsigned on_cnt;
        segs = frame_segs(mm, ss);
        for (int d = 0; d < 4; d++) begin
            @(negedge clk);
            check_eq($sformatf("%s_d%0d_seg", tag, d), o_seg, segs[7*d +: 7]);
            check_eq($sformatf("%s_d%0d_dead", tag, d), o_digit_sel, 4'b0000);
            if (upd_dig == d) begin
                i_minutes = nm;
                i_seconds = ns;
                i_blink   = nb;
            end
            exp_sel = lit[d] ? (4'b0001 << d) : 4'b0000;
            exp_dp  = lit[d] && (d == 2);
            on_cnt  = 0;
            for (int k = 0; k < 9; k++) begin
                @(negedge clk);
                if (o_digit_sel === exp_sel && o_dp === exp_dp &&
                    o_seg === segs[7*d +: 7] && o_frame_done === (d == 3 && k == 8))
                    on_cnt++;
            end
            check_eq($sformatf("%s_d%0d_on", tag, d), on_cnt, 9);
        end
        check_eq($sformatf("%s_commit", tag), o_frame_done, 1'b1);
    endtask

    // Called at the negedge of reset release (cycle 0); returns at cycle 40.
    task automatic wait_first_commit(input string tag);
        int unsigned bad;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (o_digit_sel != 4'b0000 || o_seg != 7'b0 || o_dp || o_frame_done) bad++;
            @(negedge clk);
        end
        check_eq({tag, "_blank"}, bad, 0);
        check_eq({tag, "_fdone"}, o_frame_done, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_eq("reset_state", {o_seg, o_dp, o_digit_sel, o_frame_done}, 0);
        rst = 1'b1;
        wait_first_commit("boot");

        check_frame("F1", 45, 7, 4'hF, 4, 6'd45, 6'd7, 1'b0);
        check_frame("F2", 45, 7, 4'hF, 1, 6'd45, 6'd8, 1'b0);
        check_frame("F3", 45, 8, 4'hF, 3, 6'd59, 6'd59, 1'b0);
        check_frame("F4", 45, 8, 4'hF, 4, 6'd59, 6'd59, 1'b0);
        check_frame("F5", 59, 59, 4'hF, 0, 6'd63, 6'd60, 1'b0);
        check_frame("F6", 63, 60, 4'hF, 4, 6'd63, 6'd60, 1'b0);

        check_frame("B7", 63, 60, 4'hF, 0, 6'd63, 6'd60, 1'b1);
        check_frame("B8", 63, 60, 4'hF, 4, 6'd63, 6'd60, 1'b1);
        check_frame("B9", 63, 60, 4'h0, 4, 6'd63, 6'd60, 1'b1);
        check_frame("B10", 63, 60, 4'h0, 4, 6'd63, 6'd60, 1'b1);
        check_frame("B11", 63, 60, 4'hF, 4, 6'd63, 6'd60, 1'b1);
        check_frame("B12", 63, 60, 4'hF, 4, 6'd63, 6'd60, 1'b1);
        check_frame("B13", 63, 60, 4'b1110, 1, 6'd63, 6'd60, 1'b0);
        check_frame("B14", 63, 60, 4'hF, 2, 6'd63, 6'd60, 1'b1);
        check_frame("B15", 63, 60, 4'hF, 4, 6'd63, 6'd60, 1'b1);
        check_frame("B16", 63, 60, 4'h0, 4, 6'd63, 6'd60, 1'b1);

        i_blink = 1'b0;
        repeat (25) @(negedge clk);
        check_eq("rst_pre_sel", o_digit_sel, 4'b0100);
        #2 rst = 1'b0;
        #1 check_eq("rst_async", {o_seg, o_dp, o_digit_sel, o_frame_done}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        wait_first_commit("reboot");
        check_frame("R1", 63, 60, 4'hF, 4, 6'd63, 6'd60, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
